// File: rtl/nx_fifo_mon_if.sv
// Handshake and status bundle for nx_fifo_mon.
// master: the producer/consumer side that drives requests and write data.
// slave: the FIFO side that returns head data and occupancy status.
interface nx_fifo_mon_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 132
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wen;
  logic             ren;
  logic             clear;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    used_slots;
  logic [CW-1:0]    free_slots;

  modport master (
    output wen, ren, clear, wdata,
    input  rdata, empty, full, almost_full, almost_empty, used_slots, free_slots
  );

  modport slave (
    input  wen, ren, clear, wdata,
    output rdata, empty, full, almost_full, almost_empty, used_slots, free_slots
  );
endinterface

// File: rtl/nx_fifo_mon.sv
// nx_fifo_mon: synchronous FIFO of any depth from 2 to 1024.
// Features: first-word-fall-through head, programmable almost-full/almost-empty
// levels, registered overflow/underflow pulses with sticky copies, and a
// high-water-mark monitor.
// Pointers wrap by explicit compare so non-power-of-two depths work.
module nx_fifo_mon #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 132,
  parameter int DATA_RESET = 1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  nx_fifo_mon_if.slave        bus,
  input  logic [CW-1:0]       af_thresh,
  input  logic [CW-1:0]       ae_thresh,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow,
  output logic                overflow_sticky,
  output logic                underflow_sticky,
  output logic [CW-1:0]       high_water
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  // Pointer advance with wrap at the last physical entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + AW'(1);
  endfunction

  // Unsigned maximum of two occupancy values.
  function automatic logic [CW-1:0] cnt_max(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             is_empty;
  logic             is_full;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_req;
  logic             udf_req;
  logic             ovf_p1;
  logic             udf_p1;
  logic             ovf_st;
  logic             udf_st;
  logic [CW-1:0]    hw;

  // Status decode from the count register only, so flags move on edges.
  // The exception is the almost flags, which also follow the threshold inputs.
  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH_C);

  // A flush masks both requests; a full FIFO drops writes even alongside a read.
  assign wr_ok   = bus.wen && !is_full  && !bus.clear;
  assign rd_ok   = bus.ren && !is_empty && !bus.clear;
  assign ovf_req = bus.wen &&  is_full  && !bus.clear;
  assign udf_req = bus.ren &&  is_empty && !bus.clear;

  // Next occupancy: flush wins, otherwise net of accepted read and write.
  always_comb begin
    count_nxt = count;
    if (bus.clear) begin
      count_nxt = '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Storage array; optionally cleared by reset, never touched by clear.
  if (DATA_RESET != 0) begin : g_mem_rst
    // Write port with storage reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
        mem[wptr] <= bus.wdata;
      end
    end
  end else begin : g_mem_nrst
    // Write port without storage reset.
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= bus.wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (bus.clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= ptr_inc(wptr);
        if (rd_ok) rptr <= ptr_inc(rptr);
      end
    end
  end

  // ---- stage p1: registered error pulses, sticky flags, high-water mark ----
  // Error pulses and sticky flags; a new error outranks err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p1 <= 1'b0;
      udf_p1 <= 1'b0;
      ovf_st <= 1'b0;
      udf_st <= 1'b0;
    end else begin
      ovf_p1 <= ovf_req;
      udf_p1 <= udf_req;
      if (ovf_req)      ovf_st <= 1'b1;
      else if (err_clr) ovf_st <= 1'b0;
      if (udf_req)      udf_st <= 1'b1;
      else if (err_clr) udf_st <= 1'b0;
    end
  end

  // High-water mark tracks the peak of the next count.
  // A flush zeroes it; err_clr restarts it from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw <= '0;
    end else if (bus.clear) begin
      hw <= '0;
    end else if (err_clr) begin
      hw <= count_nxt;
    end else begin
      hw <= cnt_max(hw, count_nxt);
    end
  end

  assign bus.rdata        = is_empty ? '0 : mem[rptr];
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (count >= af_thresh);
  assign bus.almost_empty = (count <= ae_thresh);
  assign bus.used_slots   = count;
  assign bus.free_slots   = DEPTH_C - count;

  assign overflow         = ovf_p1;
  assign underflow        = udf_p1;
  assign overflow_sticky  = ovf_st;
  assign underflow_sticky = udf_st;
  assign high_water       = hw;

endmodule

// File: tb/tb_nx_fifo_mon.sv
// Self-checking bench for nx_fifo_mon at DEPTH=5, WIDTH=16.
// A queue model holds expected contents: writes push, accepted reads pop and
// compare against the head data the DUT presents.
module tb_nx_fifo_mon;
  localparam int DEPTH = 5;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CW-1:0]    af_thresh = 3'd3;
  logic [CW-1:0]    ae_thresh = 3'd1;
  logic             err_clr = 1'b0;
  logic             overflow, underflow, overflow_sticky, underflow_sticky;
  logic [CW-1:0]    high_water;

  nx_fifo_mon_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  nx_fifo_mon #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .af_thresh        (af_thresh),
    .ae_thresh        (ae_thresh),
    .err_clr          (err_clr),
    .overflow         (overflow),
    .underflow        (underflow),
    .overflow_sticky  (overflow_sticky),
    .underflow_sticky (underflow_sticky),
    .high_water       (high_water)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  int               hw_m = 0;
  logic             ovf_m = 1'b0, udf_m = 1'b0;
  logic             ovf_st_m = 1'b0, udf_st_m = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ":empty"},   64'(bus.empty),        64'(n == 0));
    check({tag, ":full"},    64'(bus.full),         64'(n == DEPTH));
    check({tag, ":used"},    64'(bus.used_slots),   64'(n));
    check({tag, ":free"},    64'(bus.free_slots),   64'(DEPTH - n));
    check({tag, ":afull"},   64'(bus.almost_full),  64'(n >= int'(af_thresh)));
    check({tag, ":aempty"},  64'(bus.almost_empty), 64'(n <= int'(ae_thresh)));
    check({tag, ":rdata"},   64'(bus.rdata),        (n == 0) ? 64'd0 : 64'(q[0]));
    check({tag, ":ovf"},     64'(overflow),         64'(ovf_m));
    check({tag, ":udf"},     64'(underflow),        64'(udf_m));
    check({tag, ":ovf_st"},  64'(overflow_sticky),  64'(ovf_st_m));
    check({tag, ":udf_st"},  64'(underflow_sticky), 64'(udf_st_m));
    check({tag, ":hw"},      64'(high_water),       64'(hw_m));
  endtask

  // One clock of stimulus; the model is advanced alongside the DUT.
  task automatic cyc(input string tag, input logic w, input logic r, input logic c,
                     input logic e, input logic [WIDTH-1:0] d);
    int n;
    logic wr, rd;
    logic [WIDTH-1:0] head;
    n = q.size();
    bus.wen = w; bus.ren = r; bus.clear = c; bus.wdata = d; err_clr = e;
    wr    = w && (n < DEPTH) && !c;
    rd    = r && (n > 0) && !c;
    ovf_m = w && (n == DEPTH) && !c;
    udf_m = r && (n == 0) && !c;
    #1;
    if (rd) begin
      head = q.pop_front();
      check({tag, ":rd_data"}, 64'(bus.rdata), 64'(head));
    end
    if (c) q.delete();
    else if (wr) q.push_back(d);
    if (ovf_m) ovf_st_m = 1'b1; else if (e) ovf_st_m = 1'b0;
    if (udf_m) udf_st_m = 1'b1; else if (e) udf_st_m = 1'b0;
    n = q.size();
    if (c) hw_m = 0;
    else if (e) hw_m = n;
    else if (n > hw_m) hw_m = n;
    @(posedge clk);
    #1;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; bus.wdata = '0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    check_all("post_reset");

    // Fill to full, then an extra write must overflow and leave contents alone.
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 0, 0, 0, 16'hA0 + 16'(i));
    cyc("ovf_write", 1, 0, 0, 0, 16'hBAD0);
    cyc("ovf_idle", 0, 0, 0, 0, '0);

    // Drain, then restart the high-water mark from empty.
    for (int i = 0; i < DEPTH; i++) cyc("drain", 0, 1, 0, 0, '0);
    cyc("errclr0", 0, 0, 0, 1, '0);

    // Alternating write/read pairs exercise pointer wrap at a non-power-of-two depth.
    for (int i = 0; i < 12; i++) begin
      cyc("alt_w", 1, 0, 0, 0, 16'h1000 + 16'(i));
      cyc("alt_r", 0, 1, 0, 0, '0);
    end

    // Full plus simultaneous read and write: read taken, write dropped.
    for (int i = 0; i < DEPTH; i++) cyc("refill", 1, 0, 0, 0, 16'h2000 + 16'(i));
    cyc("full_wr_rd", 1, 1, 0, 0, 16'hDEAD);
    cyc("full_wr_rd_idle", 0, 0, 0, 0, '0);

    // Threshold walk up and down after a flush and high-water restart.
    cyc("flush", 0, 0, 1, 0, '0);
    cyc("errclr1", 0, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) cyc("thr_up", 1, 0, 0, 0, 16'h3000 + 16'(i));
    af_thresh = 3'd5;
    #1;
    check("af_live", 64'(bus.almost_full), 64'd0);
    af_thresh = 3'd3;
    #1;
    check("af_restore", 64'(bus.almost_full), 64'd1);
    for (int i = 0; i < 4; i++) cyc("thr_down", 0, 1, 0, 0, '0);

    // Underflow pulse, sticky survives err_clr on a new underflow, then clears.
    cyc("udf", 0, 1, 0, 0, '0);
    cyc("udf_errclr", 0, 1, 0, 1, '0);
    cyc("errclr2", 0, 0, 0, 1, '0);
    cyc("udf_idle", 0, 0, 0, 0, '0);

    // Clear beats a concurrent write; next write shows one cycle later.
    for (int i = 0; i < 3; i++) cyc("pre_clr", 1, 0, 0, 0, 16'h4000 + 16'(i));
    cyc("clr_wen", 1, 0, 1, 0, 16'h4444);
    cyc("post_clr_w", 1, 0, 0, 0, 16'h5555);

    // Asynchronous reset in the middle of a fill.
    cyc("mid_fill", 1, 0, 0, 0, 16'h6666);
    #2;
    rst = 1'b1;
    #1;
    q.delete(); hw_m = 0;
    ovf_m = 1'b0; udf_m = 1'b0; ovf_st_m = 1'b0; udf_st_m = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc("after_rst", 1, 0, 0, 0, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
